func_table_eval: RTL and testbench

- Parametrised, registered successor to the fixed 2-bit two-operand gate-level function blocks.
- The function c = f(a,b) is a programmable truth table, indexed by {a,b}, instead of fixed gates.
- Operands enter through a valid/ready input; results leave through a valid/ready output.
- Sits between lab stimulus logic and downstream checkers; the table is loaded at run time through a config write port.

---
 rtl/func_table_pkg.sv | 18 +
 rtl/func_table_mem.sv | 36 +++
 rtl/func_table_eval.sv | 157 +++++++++++++++
 tb/tb_func_table_eval.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/func_table_pkg.sv
// Shared types and helpers for the programmable two-operand function table.
//   state_t    : controller states (INIT clears the table, RUN serves lookups)
//   CNT_W      : width of the optional output-handshake counter
//   calc_depth : number of table entries for a given operand width
package func_table_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int calc_depth(input int in_w);
    return 1 << (2 * in_w);
  endfunction

endpackage

// File: rtl/func_table_mem.sv
// Flop-based truth-table storage: one synchronous write port and one
// combinational read port. Because the read is combinational and the
// write lands at the clock edge, a read and a write to the same entry in
// the same cycle return the old contents.
//   clk    : rising-edge clock
//   we     : write strobe
//   waddr  : write index
//   wdata  : write value
//   raddr  : read index
//   rdata  : read value (combinational)
module func_table_mem #(
  parameter int AW    = 4,
  parameter int OUT_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [OUT_W-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  // Contents are not reset here; the controller clears them after reset.
  logic [OUT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/func_table_eval.sv
// Registered, programmable two-operand function evaluator: c = f(a,b) where
// f is a run-time loaded truth table indexed by {a,b}.
// After reset the table is cleared one entry per cycle (INIT); init_done
// rises once the clear has finished and the block serves lookups (RUN).
//   clk, rst_n        : clock, asynchronous active-low reset
//   cfg_we/addr/data  : table write port (ignored during INIT)
//   init_done         : table clear complete
//   in_valid/in_ready : operand handshake, operands a and b
//   out_valid/out_ready : result handshake, result c (1-cycle latency)
// Optional build macro FUNC_TABLE_EVAL_CNT_EN adds eval_count, a saturating
// count of output handshakes cleared only by reset.
module func_table_eval
  import func_table_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int OUT_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [2*IN_W-1:0]   cfg_addr,
  input  logic [OUT_W-1:0]    cfg_data,
  output logic                init_done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     a,
  input  logic [IN_W-1:0]     b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    c
`ifdef FUNC_TABLE_EVAL_CNT_EN
  ,
  output logic [CNT_W-1:0]    eval_count
`endif
);

  localparam int AW    = 2 * IN_W;
  localparam int DEPTH = calc_depth(IN_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t           state, state_nxt;
  logic [AW-1:0]    ptr;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [OUT_W-1:0] mem_wdata;
  logic [OUT_W-1:0] mem_rdata;

  logic [AW-1:0]    raddr_p0;
  logic             acc_p0;
  logic             ready_p0;

  logic             vld_p1;
  logic [OUT_W-1:0] c_p1;
  logic             done_p1;

  // ---- Stage p0: operand address, table lookup, accept decision ----
  assign raddr_p0 = {a, b};
  assign acc_p0   = in_valid && ready_p0;

  func_table_mem #(
    .AW    (AW),
    .OUT_W (OUT_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (raddr_p0),
    .rdata (mem_rdata)
  );

  // State register and clear pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        ptr <= ptr + AW'(1);
      end
    end
  end

  // Next-state logic: INIT exits once the last entry is cleared; RUN is terminal
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (ptr == AW'(DEPTH - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Output logic: the clear sequence owns the write port during INIT
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cfg_addr;
    mem_wdata = cfg_data;
    ready_p0  = 1'b0;
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = '0;
      end
      RUN: begin
        mem_we   = cfg_we;
        ready_p0 = !vld_p1 || out_ready;
      end
      default: ;
    endcase
  end

  // ---- Stage p1: registered result and status ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      c_p1    <= '0;
      done_p1 <= 1'b0;
    end else begin
      done_p1 <= (state == RUN);
      if (acc_p0) begin
        vld_p1 <= 1'b1;
        c_p1   <= mem_rdata;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign in_ready  = ready_p0;
  assign out_valid = vld_p1;
  assign c         = c_p1;
  assign init_done = done_p1;

`ifdef FUNC_TABLE_EVAL_CNT_EN
  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (vld_p1 && out_ready) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign eval_count = cnt_p1;
`else
  // Handshake counter not built; sat_inc remains unused in this configuration.
`endif

endmodule

// File: tb/tb_func_table_eval.sv
module tb_func_table_eval;
  import func_table_pkg::*;

  localparam int IN_W  = 2;
  localparam int OUT_W = 2;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [1:0] cfg_data;
  logic       init_done;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] c;
`ifdef FUNC_TABLE_EVAL_CNT_EN
  logic [15:0] eval_count;
`endif

  always #5 clk = ~clk;

  func_table_eval #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .init_done (init_done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
`ifdef FUNC_TABLE_EVAL_CNT_EN
    ,
    .eval_count(eval_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the table as the user programmed it, and the results
  // owed to the consumer in order.
  logic [1:0] model [DEPTH];
  logic [1:0] sb [$];
  int         hs_model;
  logic       last_acc;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] exp;
  } vec_t;
  vec_t vecs [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 2'b00;
    sb.delete();
    hs_model = 0;
    last_acc = 1'b0;
  endtask

  // One clock cycle in RUN. Entered and left at a falling edge.
  task automatic step(input logic iv, input logic [1:0] ia, input logic [1:0] ib,
                      input logic ior, input logic iwe, input logic [3:0] iaddr,
                      input logic [1:0] idata);
    logic exp_ov;
    in_valid = iv; a = ia; b = ib; out_ready = ior;
    cfg_we = iwe; cfg_addr = iaddr; cfg_data = idata;
    #1;
    exp_ov = (sb.size() != 0);
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, !exp_ov || ior);
    last_acc = iv && (!exp_ov || ior);
    if (exp_ov && ior) begin
      chk("c_result", c, sb[0]);
      void'(sb.pop_front());
      if (hs_model < 65535) hs_model++;
    end
    if (last_acc) sb.push_back(model[{ia, ib}]);
    if (iwe) model[iaddr] = idata;
    @(negedge clk);
`ifdef FUNC_TABLE_EVAL_CNT_EN
    chk("eval_count", eval_count, hs_model);
`endif
  endtask

  // Counts rising edges from reset release until init_done; drives junk
  // operands and config writes early in INIT, which must be ignored.
  task automatic wait_init();
    int n = 0;
    logic ir_bad = 1'b0;
    in_valid = 1'b1; a = 2'b01; b = 2'b01;
    cfg_we = 1'b1; cfg_addr = 4'h5; cfg_data = 2'b11;
    rst_n = 1'b1;
    while (!init_done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n < DEPTH && in_ready) ir_bad = 1'b1;
      if (n == 8) begin
        in_valid = 1'b0;
        cfg_we   = 1'b0;
      end
    end
    chk("init_latency", n, DEPTH + 1);
    chk("in_ready_during_init", ir_bad, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] held_c;
    logic [1:0] pa [4];
    int idx;
    logic riv;
    logic [1:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_clear();

    for (int i = 0; i < DEPTH; i++) begin
      vecs[i].a   = 2'(i >> 2);
      vecs[i].b   = 2'(i);
      vecs[i].exp = 2'(i >> 2) ^ 2'(i);
    end
    vecs[11] = '{a: 2'b10, b: 2'b11, exp: 2'b01};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_c", c, 2'b00);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);

    wait_init();

    // Cleared table: every address reads 0 (including 5, written during INIT)
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'(i >> 2), 2'(i), 1'b1, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);

    // Program XOR table, then sweep at full throughput
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, '0, '0, 1'b1, 1'b1, 4'(i), 2'(i >> 2) ^ 2'(i));
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, 1'b1, 1'b0, '0, '0);
      chk("sweep_valid", out_valid, 1'b1);
      chk("sweep_c", c, vecs[i].exp);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);

    // Backpressure: 5 stalled cycles with a pair waiting
    pa[0] = 2'b00; pa[1] = 2'b01; pa[2] = 2'b10; pa[3] = 2'b11;
    idx = 0;
    held_c = '0;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      step(1'b1, pa[idx], ~pa[idx], !(cyc >= 1 && cyc <= 5), 1'b0, '0, '0);
      if (cyc == 0) held_c = c;
      if (cyc >= 1 && cyc <= 5) begin
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_c_hold", c, held_c);
        chk("stall_out_valid", out_valid, 1'b1);
      end
      if (last_acc) idx++;
    end
    chk("bp_all_accepted", idx, 4);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    chk("bp_drained", out_valid, 1'b0);

    // Same-cycle write and accept at entry 6: old value is returned
    step(1'b0, '0, '0, 1'b1, 1'b1, 4'h6, 2'b00);
    step(1'b1, 2'b01, 2'b10, 1'b1, 1'b1, 4'h6, 2'b11);
    chk("same_cycle_old", c, 2'b00);
    step(1'b1, 2'b01, 2'b10, 1'b1, 1'b0, '0, '0);
    chk("same_cycle_new", c, 2'b11);
    // Rewrite while the result is held must not change it
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'h6, 2'b01);
    chk("held_after_rewrite", c, 2'b11);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);

    // Randomised traffic with writes and backpressure
    riv = 1'b0; ra = '0; rb = '0;
    for (int k = 0; k < 400; k++) begin
      if (!(riv && !last_acc)) begin
        riv = 1'($urandom_range(0, 1));
        ra  = 2'($urandom_range(0, 3));
        rb  = 2'($urandom_range(0, 3));
      end
      step(riv, ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);

    // Reset while a result is stalled
    step(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    chk("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_init_done", init_done, 1'b0);
    chk("midrst_c", c, 2'b00);
    chk("midrst_in_ready", in_ready, 1'b0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    wait_init();

`ifdef FUNC_TABLE_EVAL_CNT_EN
    for (int i = 0; i < 20; i++) step(1'b1, 2'(i), 2'(i >> 2), 1'b1, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    chk("count_20", eval_count, 16'd20);
`endif

    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'(i >> 2), 2'(i), 1'b1, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);

`ifdef FUNC_TABLE_EVAL_CNT_EN
    for (int i = 0; i < 65540; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; cfg_we = 1'b0;
      @(negedge clk);
      if (sb.size() == 0) sb.push_back(2'b00);
      else if (hs_model < 65535) hs_model++;
    end
    chk("count_saturated", eval_count, 16'hFFFF);
    sb.delete(); sb.push_back(2'b00);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    chk("count_stays_sat", eval_count, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
